// File: rtl/adder_pkg.sv
// Shared constants for the adder sequence driver: default sizes, FSM encoding
// and the count-clamping helper used when a run is started.
package adder_pkg;

  localparam int ADD_WIDTH = 8;
  localparam int ADD_DEPTH = 8;
  localparam int ADD_AW    = 3;
  localparam int ADD_REC_W = ADD_WIDTH + 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t DRIVE   = 2'd1;
  localparam state_t CAPTURE = 2'd2;
  localparam state_t DONE    = 2'd3;

  function automatic int clampCount(input int count, input int depth);
    return (count > depth) ? depth : count;
  endfunction

endpackage

// File: rtl/adder_vec_ram.sv
// Dual-table register file: operand vectors (write port + combinational read)
// and captured results (write port + registered readback).
module adder_vec_ram
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int DEPTH = ADD_DEPTH,
  parameter int AW    = ADD_AW,
  parameter int REC_W = WIDTH + 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             opWr,
  input  logic [AW-1:0]    opWrAddr,
  input  logic             opWrSA,
  input  logic [WIDTH-1:0] opWrA,
  input  logic [WIDTH-1:0] opWrB,
  input  logic [AW-1:0]    opRdAddr,
  output logic             opRdSA,
  output logic [WIDTH-1:0] opRdA,
  output logic [WIDTH-1:0] opRdB,
  input  logic             resWr,
  input  logic [AW-1:0]    resWrAddr,
  input  logic [REC_W-1:0] resWrData,
  input  logic [AW-1:0]    resRdAddr,
  output logic [REC_W-1:0] resRdData
);

  logic             opSA  [DEPTH];
  logic [WIDTH-1:0] opA   [DEPTH];
  logic [WIDTH-1:0] opB   [DEPTH];
  logic [REC_W-1:0] result[DEPTH];

  // Table contents are deliberately not reset so results survive an aborted run.
  always_ff @(posedge clock) begin
    if (opWr) begin
      opSA[opWrAddr] <= opWrSA;
      opA[opWrAddr]  <= opWrA;
      opB[opWrAddr]  <= opWrB;
    end
    if (resWr) begin
      result[resWrAddr] <= resWrData;
    end
  end

  assign opRdSA = opSA[opRdAddr];
  assign opRdA  = opA[opRdAddr];
  assign opRdB  = opB[opRdAddr];

  // Registered read sees the pre-write value when the same entry is captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resRdData <= '0;
    end else begin
      resRdData <= result[resRdAddr];
    end
  end

endmodule

// File: rtl/adder_seq_driver.sv
// Initiator for the combinational add/subtract unit: replays a table of operand
// vectors into the adder and captures {carry, result} for each into a result table.
module adder_seq_driver
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int DEPTH = ADD_DEPTH,
  parameter int AW    = ADD_AW
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iWr,
  input  logic [AW-1:0]    iWrAddr,
  input  logic             iWrSA,
  input  logic [WIDTH-1:0] iWrData_a,
  input  logic [WIDTH-1:0] iWrData_b,
  input  logic [AW:0]      iCount,
  input  logic             iStart,
  output logic             oBusy,
  output logic             oDone,
  output logic [AW:0]      oCarryCnt,
  output logic             oAdd_SA,
  output logic [WIDTH-1:0] oAdd_a,
  output logic [WIDTH-1:0] oAdd_b,
  input  logic [WIDTH:0]   iAdd_Data,
  input  logic             iAdd_C,
  input  logic [AW-1:0]    iRdAddr,
  output logic [WIDTH+1:0] oRdData
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW + 1)'(1);

  state_t           state;
  logic [AW-1:0]    idx;
  logic [AW:0]      cnt;
  logic [AW:0]      startCount;
  logic             opWrEn;
  logic             resWrEn;
  logic             opRdSA;
  logic [WIDTH-1:0] opRdA;
  logic [WIDTH-1:0] opRdB;

  assign startCount = (AW + 1)'(clampCount(int'(iCount), DEPTH));
  assign opWrEn     = iWr && (state == IDLE);
  assign resWrEn    = (state == CAPTURE);

  adder_vec_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW),
    .REC_W(WIDTH + 2)
  ) vecRam (
    .clock    (iClk),
    .reset    (iRst),
    .opWr     (opWrEn),
    .opWrAddr (iWrAddr),
    .opWrSA   (iWrSA),
    .opWrA    (iWrData_a),
    .opWrB    (iWrData_b),
    .opRdAddr (idx),
    .opRdSA   (opRdSA),
    .opRdA    (opRdA),
    .opRdB    (opRdB),
    .resWr    (resWrEn),
    .resWrAddr(idx),
    .resWrData({iAdd_C, iAdd_Data}),
    .resRdAddr(iRdAddr),
    .resRdData(oRdData)
  );

  // Each vector takes a DRIVE cycle (adder inputs registered, then held) and a
  // CAPTURE cycle (adder output sampled), so the adder sees stable inputs for a full cycle.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oCarryCnt <= '0;
      oAdd_SA   <= 1'b0;
      oAdd_a    <= '0;
      oAdd_b    <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            if (startCount != '0) begin
              idx       <= '0;
              cnt       <= startCount;
              oCarryCnt <= '0;
              oBusy     <= 1'b1;
              state     <= DRIVE;
            end else begin
              oDone <= 1'b1;
            end
          end
        end
        DRIVE: begin
          oAdd_SA <= opRdSA;
          oAdd_a  <= opRdA;
          oAdd_b  <= opRdB;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          if (iAdd_C && (oCarryCnt != DEPTH_CNT)) begin
            oCarryCnt <= oCarryCnt + ONE_CNT;
          end
          if ({1'b0, idx} == (cnt - ONE_CNT)) begin
            oDone <= 1'b1;
            oBusy <= 1'b0;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_driver.sv
// Self-checking bench for adder_seq_driver with a behavioural adder beside it and
// a reference model of operand/result tables built from plain integer arithmetic.
module tb_adder_seq_driver;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iWr;
  logic [2:0] iWrAddr;
  logic       iWrSA;
  logic [7:0] iWrData_a;
  logic [7:0] iWrData_b;
  logic [3:0] iCount;
  logic       iStart;
  logic       oBusy;
  logic       oDone;
  logic [3:0] oCarryCnt;
  logic       oAdd_SA;
  logic [7:0] oAdd_a;
  logic [7:0] oAdd_b;
  logic [8:0] iAdd_Data;
  logic       iAdd_C;
  logic [2:0] iRdAddr;
  logic [9:0] oRdData;

  int checks = 0;
  int errors = 0;

  logic       modelSA [8];
  logic [7:0] modelA  [8];
  logic [7:0] modelB  [8];
  logic [9:0] modelRes[8];

  always #5 iClk = ~iClk;

  adder_seq_driver dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iWr      (iWr),
    .iWrAddr  (iWrAddr),
    .iWrSA    (iWrSA),
    .iWrData_a(iWrData_a),
    .iWrData_b(iWrData_b),
    .iCount   (iCount),
    .iStart   (iStart),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oCarryCnt(oCarryCnt),
    .oAdd_SA  (oAdd_SA),
    .oAdd_a   (oAdd_a),
    .oAdd_b   (oAdd_b),
    .iAdd_Data(iAdd_Data),
    .iAdd_C   (iAdd_C),
    .iRdAddr  (iRdAddr),
    .oRdData  (oRdData)
  );

  // Stand-in for the external Adder: 9-bit sum/difference, carry/borrow on bit 8.
  always_comb begin
    if (oAdd_SA) begin
      iAdd_Data = {1'b0, oAdd_a} - {1'b0, oAdd_b};
    end else begin
      iAdd_Data = {1'b0, oAdd_a} + {1'b0, oAdd_b};
    end
    iAdd_C = iAdd_Data[8];
  end

  function automatic logic [9:0] refResult(input logic sa, input logic [7:0] a, input logic [7:0] b);
    int r;
    logic carry;
    if (sa) begin
      r = int'(a) - int'(b);
      carry = (a < b);
    end else begin
      r = int'(a) + int'(b);
      carry = (r > 255);
    end
    return {carry, 9'(r & 511)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int addr, input logic sa, input logic [7:0] a, input logic [7:0] b);
    iWr = 1'b1;
    iWrAddr = 3'(addr);
    iWrSA = sa;
    iWrData_a = a;
    iWrData_b = b;
    @(posedge iClk); #1;
    iWr = 1'b0;
    modelSA[addr] = sa;
    modelA[addr] = a;
    modelB[addr] = b;
  endtask

  task automatic runAndWait(input logic [3:0] count, output int doneAt, output bit sawBusy);
    iCount = count;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    doneAt = -1;
    sawBusy = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (oBusy) sawBusy = 1'b1;
      if (oDone) begin
        doneAt = n;
        break;
      end
      @(posedge iClk); #1;
    end
  endtask

  task automatic modelRun(input int count, output int carries);
    carries = 0;
    for (int i = 0; i < count; i++) begin
      modelRes[i] = refResult(modelSA[i], modelA[i], modelB[i]);
      carries += int'(modelRes[i][9]);
    end
  endtask

  task automatic readRes(input int addr, output logic [9:0] data);
    iRdAddr = 3'(addr);
    @(posedge iClk); #1;
    data = oRdData;
  endtask

  task automatic checkResults(input string tag, input int count);
    logic [9:0] rd;
    for (int i = 0; i < count; i++) begin
      readRes(i, rd);
      checkOutput($sformatf("%s e%0d", tag, i), 32'(rd), 32'(modelRes[i]));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int doneAt;
    int carries;
    int cnt;
    bit sawBusy;
    bit sawDone;
    logic [9:0] rd;

    iRst = 1'b0;
    iWr = 1'b0;
    iWrAddr = '0;
    iWrSA = 1'b0;
    iWrData_a = '0;
    iWrData_b = '0;
    iCount = '0;
    iStart = 1'b0;
    iRdAddr = '0;
    #2 iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    checkOutput("reset busy", 32'(oBusy), 0);
    checkOutput("reset done", 32'(oDone), 0);
    checkOutput("reset carryCnt", 32'(oCarryCnt), 0);
    checkOutput("reset adder inputs", 32'({oAdd_SA, oAdd_a, oAdd_b}), 0);
    checkOutput("reset rdData", 32'(oRdData), 0);
    iRst = 1'b0;
    @(posedge iClk); #1;

    // Step 1: single vector
    applyStimulus(0, 1'b0, 8'h04, 8'h06);
    runAndWait(4'd1, doneAt, sawBusy);
    checkOutput("t1 doneAt", 32'(doneAt), 3);
    checkOutput("t1 busy seen", 32'(sawBusy), 1);
    modelRun(1, carries);
    checkOutput("t1 carryCnt", 32'(oCarryCnt), 32'(carries));
    checkResults("t1", 1);
    checkOutput("t1 const e0", 32'(modelRes[0]), 32'h00A);

    // Step 2: seven directed vectors
    applyStimulus(0, 1'b0, 8'h04, 8'h06);
    applyStimulus(1, 1'b0, 8'h84, 8'h80);
    applyStimulus(2, 1'b0, 8'h41, 8'h42);
    applyStimulus(3, 1'b0, 8'hC1, 8'hA1);
    applyStimulus(4, 1'b1, 8'h82, 8'h01);
    applyStimulus(5, 1'b1, 8'h40, 8'h81);
    applyStimulus(6, 1'b1, 8'h7F, 8'hFF);
    runAndWait(4'd7, doneAt, sawBusy);
    checkOutput("t2 doneAt", 32'(doneAt), 15);
    modelRun(7, carries);
    checkOutput("t2 carryCnt", 32'(oCarryCnt), 32'(carries));
    checkResults("t2", 7);

    // Step 3: zero-count start
    runAndWait(4'd0, doneAt, sawBusy);
    checkOutput("t3 doneAt", 32'(doneAt), 1);
    checkOutput("t3 busy seen", 32'(sawBusy), 0);
    checkResults("t3", 7);

    // Step 4: start and write during a run are dropped
    iCount = 4'd7;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    @(posedge iClk); #1;
    iStart = 1'b1;
    iCount = 4'd3;
    iWr = 1'b1;
    iWrAddr = 3'd0;
    iWrSA = 1'b1;
    iWrData_a = 8'hAA;
    iWrData_b = 8'h55;
    @(posedge iClk); #1;
    iStart = 1'b0;
    iWr = 1'b0;
    doneAt = -1;
    for (int n = 3; n <= 40; n++) begin
      if (oDone) begin
        doneAt = n;
        break;
      end
      @(posedge iClk); #1;
    end
    checkOutput("t4 doneAt", 32'(doneAt), 15);
    @(posedge iClk); #1;
    checkOutput("t4 no restart", 32'({oBusy, oDone}), 0);
    modelRun(7, carries);
    runAndWait(4'd1, doneAt, sawBusy);
    checkOutput("t4 rerun doneAt", 32'(doneAt), 3);
    checkOutput("t4 e0 operands", 32'({oAdd_SA, oAdd_a, oAdd_b}), 32'({1'b0, 8'h04, 8'h06}));
    checkResults("t4", 1);

    // Step 5: reset mid-run
    for (int i = 0; i < 7; i++) begin
      applyStimulus(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    iCount = 4'd7;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (4) @(posedge iClk);
    #1;
    iRst = 1'b1;
    #1;
    checkOutput("t5 busy", 32'(oBusy), 0);
    checkOutput("t5 carryCnt", 32'(oCarryCnt), 0);
    checkOutput("t5 adder inputs", 32'({oAdd_SA, oAdd_a, oAdd_b}), 0);
    sawDone = 1'b0;
    repeat (2) begin
      @(posedge iClk); #1;
      if (oDone) sawDone = 1'b1;
    end
    iRst = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(posedge iClk); #1;
      if (oDone || oBusy) sawDone = 1'b1;
    end
    checkOutput("t5 no done after abort", 32'(sawDone), 0);
    for (int i = 0; i < 2; i++) begin
      modelRes[i] = refResult(modelSA[i], modelA[i], modelB[i]);
    end
    checkResults("t5", 7);

    // Step 6: oversize count clamps to the table depth
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    runAndWait(4'd15, doneAt, sawBusy);
    checkOutput("t6 doneAt", 32'(doneAt), 17);
    modelRun(8, carries);
    checkOutput("t6 carryCnt", 32'(oCarryCnt), 32'(carries));
    checkResults("t6", 8);

    // Randomized runs of random length
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        applyStimulus(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end
      cnt = int'($urandom_range(1, 8));
      runAndWait(4'(cnt), doneAt, sawBusy);
      checkOutput($sformatf("rnd%0d doneAt", r), 32'(doneAt), 32'(2 * cnt + 1));
      modelRun(cnt, carries);
      checkOutput($sformatf("rnd%0d carryCnt", r), 32'(oCarryCnt), 32'(carries));
      checkResults($sformatf("rnd%0d", r), cnt);
    end

    readRes(0, rd);
    checkOutput("final e0", 32'(rd), 32'(modelRes[0]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
